// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch front end owning the PC.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned next PC halts fetch and sets the sticky fetch_err.
// Without it, next_pc is forced word-aligned and fetch_err stays 0.
module fetch_unit #(
    parameter int W = 32,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   pcsrc,
    input  logic [W-1:0] imm_ext,
    input  logic [W-1:0] alu_result,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4,
    output logic         fetch_err
);
    typedef enum logic [1:0] {REQ, WAIT, VALID, HALT} state_t;
    state_t state;
    logic [W-1:0] target;
    logic [W-1:0] next_pc;
    assign pc_plus4    = pc + W'(4);
    assign imem_addr   = pc;
    assign instr_valid = state == VALID;
    // the request is suppressed during the reset cycle even if state already reads REQ
    assign imem_req    = state == REQ && !rst;
    assign target      = pcsrc[1] ? alu_result & ~W'(1) : pcsrc[0] ? pc + imm_ext : pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = target;
`else
    assign next_pc = target & ~W'(3);
    assign fetch_err = 1'b0;
`endif
    // fetch sequencer: request, wait for data, hold the instruction until it retires
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc    <= RESET_PC;
            instr <= W'(32'h00000013);
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_err <= 1'b0;
`endif
        end else begin
            case (state)
                REQ:   if (imem_gnt) state <= WAIT;
                WAIT:  if (imem_rvalid) begin
                    instr <= imem_rdata;
                    state <= VALID;
                end
                VALID: if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (|next_pc[1:0]) begin
                        fetch_err <= 1'b1;
                        state     <= HALT;
                    end else begin
                        pc    <= next_pc;
                        state <= REQ;
                    end
`else
                    pc    <= next_pc;
                    state <= REQ;
`endif
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule
